// File: rtl/tiler_pkg.sv
// Shared constants, slice-index helper and read FSM state type for block_tiler.
package tiler_pkg;

   localparam int N_DEF   = 16;
   localparam int BLK_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } rd_state_e;

   // Pixel (r,c) of a BLKxBLK block lives at this slice; (0,0) is the MSB slice.
   function automatic int blk_slice_idx(input int r, input int c, input int blk);
      return blk * blk - 1 - (r * blk + c);
   endfunction

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/block_tiler_if.sv
// Pixel-in / block-out handshake bundle for block_tiler.
// slave = tiler side, master = producer/consumer side.
interface block_tiler_if #(
   parameter int N   = 16,
   parameter int BLK = 8,
   parameter int RW  = 4,
   parameter int CW  = 4
) ();
   logic                 pix_in_valid;
   logic                 pix_in_ready;
   logic [N-1:0]         pix_in_data;
   logic                 blk_out_valid;
   logic                 blk_out_ready;
   logic [N*BLK*BLK-1:0] blk_out_data;
   logic [RW-1:0]        blk_row;
   logic [CW-1:0]        blk_col;
   logic                 blk_last;

   modport slave (
      input  pix_in_valid, pix_in_data, blk_out_ready,
      output pix_in_ready, blk_out_valid, blk_out_data, blk_row, blk_col, blk_last
   );

   modport master (
      output pix_in_valid, pix_in_data, blk_out_ready,
      input  pix_in_ready, blk_out_valid, blk_out_data, blk_row, blk_col, blk_last
   );
endinterface

// File: rtl/tiler_line_bank.sv
// One band of BLK image rows: single pixel write port, parallel BLKxBLK block read by column.
module tiler_line_bank
   import tiler_pkg::*;
#(
   parameter int N     = 16,
   parameter int IMG_W = 128,
   parameter int BLK   = 8
) (
   input  logic                            clk,
   input  logic                            wr_en,
   input  logic [idx_w(BLK)-1:0]           wr_row,
   input  logic [idx_w(IMG_W)-1:0]         wr_col,
   input  logic [N-1:0]                    wr_data,
   input  logic [idx_w(IMG_W/BLK)-1:0]     rd_col,
   output logic [N*BLK*BLK-1:0]            rd_blk
);
   localparam int AW = idx_w(BLK * IMG_W);
   localparam int SW = idx_w(BLK * BLK);

   logic [N-1:0]                mem_q [BLK*IMG_W];
   logic [BLK*BLK-1:0][N-1:0]   blk_arr;

   // Pixel store; contents are data only, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[AW'(int'(wr_row) * IMG_W + int'(wr_col))] <= wr_data;
      end
   end

   // Gather the selected block column into dct2d packing.
   always_comb begin
      blk_arr = '0;
      for (int r = 0; r < BLK; r++) begin
         for (int c = 0; c < BLK; c++) begin
            blk_arr[SW'(blk_slice_idx(r, c, BLK))] =
               mem_q[AW'(r * IMG_W + int'(rd_col) * BLK + c)];
         end
      end
   end

   assign rd_blk = blk_arr;

endmodule

// File: rtl/block_tiler.sv
// Raster-to-block converter feeding dct2d: ping-pong line banks plus a block read FSM.
// Optional macro BLOCK_TILER_LEVEL_SHIFT_EN: store pixel - LEVEL_OFFSET (JPEG level shift).
//
// state | meaning
// IDLE  | waiting for the bank at rd_bank to be full
// LOAD  | issuing blocks of the current band, one column per accepted slot
module block_tiler
   import tiler_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int IMG_W        = 128,
   parameter int IMG_H        = 128,
   parameter int BLK          = BLK_DEF,
   parameter int LEVEL_OFFSET = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   block_tiler_if.slave bus
);
   localparam int NBC = IMG_W / BLK;
   localparam int NBR = IMG_H / BLK;
   localparam int CA  = idx_w(IMG_W);
   localparam int RA  = idx_w(BLK);
   localparam int CW  = idx_w(NBC);
   localparam int RW  = idx_w(NBR);
   localparam int BW  = N * BLK * BLK;

   if (IMG_W % BLK != 0) begin : g_chk_w
      $error("block_tiler: IMG_W must be a multiple of BLK");
   end
   if (IMG_H % BLK != 0) begin : g_chk_h
      $error("block_tiler: IMG_H must be a multiple of BLK");
   end
   if (BLK < 2) begin : g_chk_blk
      $error("block_tiler: BLK must be 2 or more");
   end
   if (LEVEL_OFFSET < 0) begin : g_chk_off
      $error("block_tiler: LEVEL_OFFSET must be non-negative");
   end

   logic [CA-1:0] wr_col_q, wr_col_d;
   logic [RA-1:0] wr_row_q, wr_row_d;
   logic          wr_bank_q, wr_bank_d;
   logic [1:0]    full_q, full_d;

   rd_state_e     state_q, state_d;
   logic          rd_bank_q, rd_bank_d;
   logic [CW-1:0] rd_col_q, rd_col_d;
   logic [RW-1:0] rd_band_q, rd_band_d;

   logic          out_valid_q, out_valid_d;
   logic [BW-1:0] out_data_q, out_data_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          out_last_q, out_last_d;

   logic          pix_ready, pix_hs, fill_done, drain_done;
   logic [N-1:0]  wr_pix;
   logic [BW-1:0] blk0, blk1, blk_sel;

   // Ready comes straight from the registered bank flags, held low in reset.
   assign pix_ready = rst_n & ~full_q[wr_bank_q];
   assign pix_hs    = bus.pix_in_valid & pix_ready;

`ifdef BLOCK_TILER_LEVEL_SHIFT_EN
   assign wr_pix = bus.pix_in_data - N'(LEVEL_OFFSET);
`else
   assign wr_pix = bus.pix_in_data;
`endif

   tiler_line_bank #(.N(N), .IMG_W(IMG_W), .BLK(BLK)) u_bank0 (
      .clk     (clk),
      .wr_en   (pix_hs & ~wr_bank_q),
      .wr_row  (wr_row_q),
      .wr_col  (wr_col_q),
      .wr_data (wr_pix),
      .rd_col  (rd_col_q),
      .rd_blk  (blk0)
   );

   tiler_line_bank #(.N(N), .IMG_W(IMG_W), .BLK(BLK)) u_bank1 (
      .clk     (clk),
      .wr_en   (pix_hs & wr_bank_q),
      .wr_row  (wr_row_q),
      .wr_col  (wr_col_q),
      .wr_data (wr_pix),
      .rd_col  (rd_col_q),
      .rd_blk  (blk1)
   );

   assign blk_sel = rd_bank_q ? blk1 : blk0;

   // Raster write position; completing the last row of a band hands the bank over.
   always_comb begin
      wr_col_d  = wr_col_q;
      wr_row_d  = wr_row_q;
      wr_bank_d = wr_bank_q;
      fill_done = 1'b0;
      if (pix_hs) begin
         if (wr_col_q == CA'(IMG_W - 1)) begin
            wr_col_d = '0;
            if (wr_row_q == RA'(BLK - 1)) begin
               wr_row_d  = '0;
               wr_bank_d = ~wr_bank_q;
               fill_done = 1'b1;
            end else begin
               wr_row_d = wr_row_q + 1'b1;
            end
         end else begin
            wr_col_d = wr_col_q + 1'b1;
         end
      end
   end

   // Fill and drain always target different banks, so both updates can apply together.
   always_comb begin
      full_d = full_q;
      if (fill_done) full_d[wr_bank_q] = 1'b1;
      if (drain_done) full_d[rd_bank_q] = 1'b0;
   end

   // Read FSM: load a block whenever the output slot is empty or being accepted.
   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_col_d    = rd_col_q;
      rd_band_d   = rd_band_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      out_last_d  = out_last_q;
      drain_done  = 1'b0;
      if (bus.blk_out_ready) out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) state_d = LOAD;
         end
         LOAD: begin
            if (!out_valid_q || bus.blk_out_ready) begin
               out_valid_d = 1'b1;
               out_data_d  = blk_sel;
               out_row_d   = rd_band_q;
               out_col_d   = rd_col_q;
               out_last_d  = (rd_band_q == RW'(NBR - 1)) && (rd_col_q == CW'(NBC - 1));
               if (rd_col_q == CW'(NBC - 1)) begin
                  rd_col_d   = '0;
                  drain_done = 1'b1;
                  rd_bank_d  = ~rd_bank_q;
                  rd_band_d  = (rd_band_q == RW'(NBR - 1)) ? '0 : rd_band_q + 1'b1;
                  state_d    = IDLE;
               end else begin
                  rd_col_d = rd_col_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_col_q    <= '0;
         wr_row_q    <= '0;
         wr_bank_q   <= 1'b0;
         full_q      <= '0;
         state_q     <= IDLE;
         rd_bank_q   <= 1'b0;
         rd_col_q    <= '0;
         rd_band_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         wr_col_q    <= wr_col_d;
         wr_row_q    <= wr_row_d;
         wr_bank_q   <= wr_bank_d;
         full_q      <= full_d;
         state_q     <= state_d;
         rd_bank_q   <= rd_bank_d;
         rd_col_q    <= rd_col_d;
         rd_band_q   <= rd_band_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.pix_in_ready  = pix_ready;
   assign bus.blk_out_valid = out_valid_q;
   assign bus.blk_out_data  = out_data_q;
   assign bus.blk_row       = out_row_q;
   assign bus.blk_col       = out_col_q;
   assign bus.blk_last      = out_last_q;

endmodule
